bbox_cmpalu: RTL and testbench
==============================

# bbox_cmpalu

Parametrised bitmap extent analyser for the compare accelerator. It accepts one COLS-wide bitmap row per handshake, up to ROWS rows per frame. From these it computes the empty margins on all four sides of the glyph: left, right, top and bottom. It also decides whether the glyph can be scaled 2x horizontally and/or vertically. It is the next generation of the fixed 64x24 compare ALU. It adds right/top margins, a valid/ready input stream, short-frame handling and a held result with acknowledge.

## Interface
Parameters:
- COLS, 24, bitmap width in pixels; bit c of row_data is column c, and column 0 is leftmost.
- ROWS, 64, maximum rows per frame; row 0 is the top row.
- HTHRESH, COLS/2, minimum total empty columns for hscale.
- VTHRESH, ROWS/2, minimum total empty rows for vscale.
- CW = $clog2(COLS+1) and RW = $clog2(ROWS+1) are local widths.

Ports (`clk` is the single clock; `rst_n` is asynchronous, active-low):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  clears all state and opens a new frame.
- row_valid  in  1  row_data is presented.
- row_data  in  COLS  one bitmap row.
- row_last  in  1  final row of the frame.
- row_ready  out  1  the block accepts a row.
- res_ack  in  1  the consumer takes the result.
- res_valid  out  1  the result is valid and held.
- lshift  out  CW  number of empty columns on the left.
- rshift  out  CW  number of empty columns on the right.
- ushift  out  RW  number of empty rows at the top.
- dshift  out  RW  number of empty rows at the bottom.
- hscale  out  1  (lshift+rshift) >= HTHRESH.
- vscale  out  1  (ushift+dshift) >= VTHRESH.
- empty  out  1  the frame contained no set pixel.
- len_err  out  1  the frame ended before ROWS rows.

## Operation
- **States:** IDLE, SCAN, CALC, DONE.
- **Reset:** state is IDLE. All outputs are 0, including row_ready and res_valid. All internal accumulators are 0.
- **start:** has priority in every state. It clears colmask (COLS bits), the row counter, first/last-row registers, the found flag and all result registers. res_valid drops. The state moves to SCAN on the next edge. Any row presented in the same cycle as start is ignored.
- **SCAN:**
  - row_ready is 1.
  - On row_valid & row_ready at row index r:
    - colmask |= row_data.
    - If row_data != 0: set first_row = r when found==0, set found=1, and set last_row = r.
    - The row index increments.
  - The frame ends on an accepted row with row_last=1, or on the accepted row r = ROWS-1, whichever comes first.
  - row_last on row ROWS-1 is normal. row_last is ignored beyond that point because the frame is forced to end.
  - At frame end the state moves to CALC and row_ready drops.
- **CALC** (one cycle) registers the results:
  - If found==0: empty=1 and lshift, rshift, ushift, dshift, hscale and vscale are all 0.
  - Otherwise:
    - lshift = index of the lowest set bit of colmask.
    - rshift = COLS-1 - index of the highest set bit.
    - ushift = first_row.
    - dshift = ROWS-1 - last_row. Rows never received in a short frame count as empty.
    - hscale and vscale follow their threshold compares. Sums are computed at CW+1 and RW+1 bits, so they cannot overflow.
  - len_err = 1 when the frame ended with fewer than ROWS rows accepted.
  - The state moves to DONE.
- **DONE:**
  - res_valid is 1 and all result outputs are held stable.
  - res_ack moves the state to IDLE and clears res_valid. The result outputs retain their values until the next start.
- **IDLE:** row_ready is 0 and rows are ignored.

## Timing
- Row throughput is one row per cycle with no bubbles. row_valid may toggle arbitrarily, and gaps have no effect on the result.
- Latency: the final row is accepted on edge E. The state is CALC during the following cycle, and res_valid=1 from edge E+1.
- Minimum frame time, from start to res_valid, for a full frame is 1 + ROWS + 1 cycles.
- res_ack in the same cycle res_valid first rises is legal: IDLE is entered on the next edge.
- start together with res_ack: start wins and the state goes to SCAN.
- rst_n asserted mid-frame clears everything immediately. No partial result is ever flagged valid.
- res_ack outside DONE is ignored.

## Test plan
- **Single pixel:** COLS=24, ROWS=64, one pixel at row 10, column 5, 64 rows, row_last on row 63. Expect lshift=5, rshift=18, ushift=10, dshift=53, hscale=1, vscale=1, empty=0, len_err=0. res_valid is 1 cycle after the last accept.
- **Full extent:** row 0 = 24'h000001, row 63 = 24'h800000, all other rows zero. Expect all shifts 0, hscale=0, vscale=0, empty=0.
- **All-zero frame:** 64 rows of zero. Expect empty=1, all shifts 0, scale flags 0.
- **Short frame:** 20 rows, pixel at row 19, column 23, row_last on row 19. Expect ushift=19, dshift=44, lshift=23, rshift=0, len_err=1, hscale=1, vscale=1.
- **Gappy input and restart:** repeat the single-pixel case with row_valid randomly low for about 50% of cycles and expect the same result. Then assert start after 30 rows of a frame and send a new frame; the result must reflect only the new frame.
- **Reset, hold and acknowledge:**
  - Assert rst_n=0 mid-SCAN: all outputs are 0 immediately.
  - In DONE, hold res_ack=0 for 10 cycles: the result stays stable.
  - Then pulse res_ack: res_valid falls on the next edge.
  - Assert start and res_ack together: the state goes to SCAN.

Source files
------------

// File: rtl/bbox_cmpalu.sv
// Bitmap extent analyser: accumulates one row per handshake and reports the empty
// margins on all four sides of the glyph plus 2x horizontal/vertical scale feasibility.
module bbox_cmpalu #(
    parameter  int COLS    = 24,
    parameter  int ROWS    = 64,
    parameter  int HTHRESH = COLS / 2,
    parameter  int VTHRESH = ROWS / 2,
    localparam int CW      = $clog2(COLS + 1),
    localparam int RW      = $clog2(ROWS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            row_valid,
    input  logic [COLS-1:0] row_data,
    input  logic            row_last,
    output logic            row_ready,
    input  logic            res_ack,
    output logic            res_valid,
    output logic [CW-1:0]   lshift,
    output logic [CW-1:0]   rshift,
    output logic [RW-1:0]   ushift,
    output logic [RW-1:0]   dshift,
    output logic            hscale,
    output logic            vscale,
    output logic            empty,
    output logic            len_err
);

    typedef enum logic [1:0] {IDLE, SCAN, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [COLS-1:0] colmask;
    logic [RW-1:0]   row_cnt;
    logic [RW-1:0]   first_row;
    logic [RW-1:0]   last_row;
    logic            found;
    logic            accept;
    logic            frame_end;
    logic [CW-1:0]   lo_idx, hi_idx;
    logic [CW-1:0]   lsh_n, rsh_n;
    logic [RW-1:0]   dsh_n;
    logic [CW:0]     hsum;
    logic [RW:0]     vsum;

    assign row_ready = (state == SCAN);
    assign res_valid = (state == DONE);

    // A row arriving together with start belongs to no frame and is dropped.
    assign accept    = row_valid && row_ready && !start;
    assign frame_end = accept && (row_last || row_cnt == RW'(ROWS - 1));

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = IDLE;
            SCAN: if (frame_end) state_nxt = CALC;
            CALC: state_nxt = DONE;
            DONE: if (res_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = SCAN;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Lowest and highest set columns of the accumulated mask.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int c = COLS - 1; c >= 0; c--)
            if (colmask[c]) lo_idx = CW'(c);
        for (int c = 0; c < COLS; c++)
            if (colmask[c]) hi_idx = CW'(c);
    end

    assign lsh_n = lo_idx;
    assign rsh_n = CW'(COLS - 1) - hi_idx;
    assign dsh_n = RW'(ROWS - 1) - last_row;
    assign hsum  = {1'b0, lsh_n} + {1'b0, rsh_n};
    assign vsum  = {1'b0, first_row} + {1'b0, dsh_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colmask   <= '0;
            row_cnt   <= '0;
            first_row <= '0;
            last_row  <= '0;
            found     <= 1'b0;
            lshift    <= '0;
            rshift    <= '0;
            ushift    <= '0;
            dshift    <= '0;
            hscale    <= 1'b0;
            vscale    <= 1'b0;
            empty     <= 1'b0;
            len_err   <= 1'b0;
        end else if (start) begin
            colmask   <= '0;
            row_cnt   <= '0;
            first_row <= '0;
            last_row  <= '0;
            found     <= 1'b0;
            lshift    <= '0;
            rshift    <= '0;
            ushift    <= '0;
            dshift    <= '0;
            hscale    <= 1'b0;
            vscale    <= 1'b0;
            empty     <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            if (accept) begin
                colmask <= colmask | row_data;
                row_cnt <= row_cnt + 1'b1;
                if (row_data != '0) begin
                    if (!found) first_row <= row_cnt;
                    found    <= 1'b1;
                    last_row <= row_cnt;
                end
            end
            if (state == CALC) begin
                // Rows never received in a short frame count toward the bottom margin.
                len_err <= (row_cnt < RW'(ROWS));
                empty   <= !found;
                if (found) begin
                    lshift <= lsh_n;
                    rshift <= rsh_n;
                    ushift <= first_row;
                    dshift <= dsh_n;
                    hscale <= (hsum >= (CW+1)'(HTHRESH));
                    vscale <= (vsum >= (RW+1)'(VTHRESH));
                end else begin
                    lshift <= '0;
                    rshift <= '0;
                    ushift <= '0;
                    dshift <= '0;
                    hscale <= 1'b0;
                    vscale <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_cmpalu.sv
// Directed bench for bbox_cmpalu: hand-computed margin results for the 24x64 default.
module tb_bbox_cmpalu;

    localparam int COLS = 24;
    localparam int ROWS = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            row_valid;
    logic [COLS-1:0] row_data;
    logic            row_last;
    logic            row_ready;
    logic            res_ack;
    logic            res_valid;
    logic [4:0]      lshift, rshift;
    logic [6:0]      ushift, dshift;
    logic            hscale, vscale, empty, len_err;

    logic [COLS-1:0] frame [ROWS];
    int checks   = 0;
    int failures = 0;

    bbox_cmpalu dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .row_valid(row_valid), .row_data(row_data), .row_last(row_last),
        .row_ready(row_ready), .res_ack(res_ack), .res_valid(res_valid),
        .lshift(lshift), .rshift(rshift), .ushift(ushift), .dshift(dshift),
        .hscale(hscale), .vscale(vscale), .empty(empty), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_result(input string tag, input int l, input int r, input int u,
                                 input int d, input bit h, input bit v, input bit e, input bit le);
        check({tag, "_lshift"}, 32'(lshift), 32'(l));
        check({tag, "_rshift"}, 32'(rshift), 32'(r));
        check({tag, "_ushift"}, 32'(ushift), 32'(u));
        check({tag, "_dshift"}, 32'(dshift), 32'(d));
        check({tag, "_hscale"}, 32'(hscale), 32'(h));
        check({tag, "_vscale"}, 32'(vscale), 32'(v));
        check({tag, "_empty"},  32'(empty),  32'(e));
        check({tag, "_lenerr"}, 32'(len_err), 32'(le));
    endtask

    task automatic clear_frame();
        for (int i = 0; i < ROWS; i++) frame[i] = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents rows 0..n-1; optional random gaps of up to three idle cycles per row.
    task automatic feed(input int n, input bit gappy, input bit use_last);
        for (int r = 0; r < n; r++) begin
            int gaps = 0;
            while (gappy && gaps < 3 && $urandom_range(0, 1) == 1) begin
                row_valid = 1'b0;
                row_data  = '1;
                @(negedge clk);
                gaps++;
            end
            row_valid = 1'b1;
            row_data  = frame[r];
            row_last  = use_last && (r == n - 1);
            @(negedge clk);
        end
        row_valid = 1'b0;
        row_last  = 1'b0;
        row_data  = '0;
    endtask

    // After the last accept: one CALC cycle, then res_valid.
    task automatic finish_frame(input string tag);
        check({tag, "_calc_ready"}, 32'(row_ready), 32'd0);
        check({tag, "_calc_valid"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        check({tag, "_done_valid"}, 32'(res_valid), 32'd1);
    endtask

    task automatic ack();
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check("ack_valid_low", 32'(res_valid), 32'd0);
    endtask

    function automatic logic [31:0] outs();
        return 32'({lshift, rshift, ushift, dshift, hscale, vscale, empty, len_err,
                    row_ready, res_valid});
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; row_valid = 1'b0; row_data = '0;
        row_last = 1'b0; res_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check("idle_ack_ignored", outs(), 32'd0);

        // Single pixel at row 10, column 5
        clear_frame();
        frame[10] = 24'h000020;
        do_start();
        check("scan_ready", 32'(row_ready), 32'd1);
        feed(64, 1'b0, 1'b1);
        finish_frame("single");
        expect_result("single", 5, 18, 10, 53, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_outs", outs(), 32'({5'd5, 5'd18, 7'd10, 7'd53, 6'b110001}));
        end
        ack();
        check("ack_retain_lshift", 32'(lshift), 32'd5);
        check("ack_retain_dshift", 32'(dshift), 32'd53);

        // Full extent
        clear_frame();
        frame[0]  = 24'h000001;
        frame[63] = 24'h800000;
        do_start();
        feed(64, 1'b0, 1'b1);
        finish_frame("full");
        expect_result("full", 0, 0, 0, 0, 0, 0, 0, 0);
        ack();

        // All-zero frame, no row_last: forced end at row 63
        clear_frame();
        do_start();
        feed(64, 1'b0, 1'b0);
        finish_frame("zero");
        expect_result("zero", 0, 0, 0, 0, 0, 0, 1, 0);
        ack();

        // Short frame: 20 rows, pixel at row 19 column 23
        clear_frame();
        frame[19] = 24'h800000;
        do_start();
        feed(20, 1'b0, 1'b1);
        finish_frame("short");
        expect_result("short", 23, 0, 19, 44, 1, 1, 0, 1);

        // start together with res_ack in DONE: start wins
        start = 1'b1; res_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; res_ack = 1'b0;
        check("start_ack_ready", 32'(row_ready), 32'd1);
        check("start_ack_valid", 32'(res_valid), 32'd0);
        check("start_ack_cleared", 32'(lshift), 32'd0);

        // Abandoned partial frame, then a restart with a row presented alongside start
        clear_frame();
        frame[2]  = 24'h000001;
        frame[29] = 24'h800000;
        feed(30, 1'b0, 1'b0);
        start = 1'b1; row_valid = 1'b1; row_data = '1;
        @(negedge clk);
        start = 1'b0; row_valid = 1'b0; row_data = '0;
        clear_frame();
        frame[10] = 24'h000020;
        feed(64, 1'b1, 1'b1);
        finish_frame("gappy");
        expect_result("gappy", 5, 18, 10, 53, 1, 1, 0, 0);

        // Reset while DONE with a non-zero result
        rst_n = 1'b0;
        #1;
        check("rst_done_outs", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-SCAN
        clear_frame();
        for (int i = 0; i < ROWS; i++) frame[i] = '1;
        do_start();
        feed(5, 1'b0, 1'b0);
        row_valid = 1'b1; row_data = '1;
        rst_n = 1'b0;
        #1;
        check("rst_scan_outs", outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_scan_idle", outs(), 32'd0);
        row_valid = 1'b0; row_data = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
